seq_ram_writer: RTL
===================

SEQ_RAM_WRITER -- requirements
Module: seq_ram_writer

Interface
REQ-001 Parameter WIDTH, default 8, data byte width in bits.
REQ-002 Parameter DEPTH, default 32, number of memory entries (power of two); AW = log2(DEPTH) = 5.
REQ-003 iClk  input  1  single clock; all state changes on rising edge.
REQ-004 iReset  input  1  asynchronous, active-high reset.
REQ-005 iValid  input  1  write request; data on iData is offered this cycle.
REQ-006 iData  input  WIDTH  byte to store.
REQ-007 oReady  output  1  block accepts a write this cycle.
REQ-008 iClear  input  1  synchronous restart of fill sequence.
REQ-009 iRdAddr  input  AW  readback address.
REQ-010 oRdData  output  WIDTH  registered readback data.
REQ-011 oCount  output  AW+1  number of entries written since reset/clear (0..DEPTH).
REQ-012 oFull  output  1  all DEPTH entries written.
REQ-013 oDone  output  1  one-cycle pulse on the fill completing.
REQ-014 oChecksum  output  WIDTH  running modulo-2^WIDTH sum of accepted bytes (see Configuration).

Function
REQ-015 FSM states: FILL and FULL; oReady = 1 in FILL, 0 in FULL (decoded from state, no combinational path from iValid).
REQ-016 Accepted write = iValid && oReady at a rising edge; iData is stored at mem[wr_ptr], wr_ptr and oCount increment by 1.
REQ-017 Writes fill addresses strictly in order 0,1,...,DEPTH-1; wr_ptr is AW bits and wraps to 0 after DEPTH-1.
REQ-018 The accepted write at address DEPTH-1 moves FSM FILL->FULL, sets oCount = DEPTH, oFull = 1, and asserts oDone for exactly the next cycle.
REQ-019 In FULL, iValid is ignored: no memory write, oCount/oChecksum unchanged, oDone stays 0.
REQ-020 iClear = 1 at a rising edge: FSM -> FILL, wr_ptr = 0, oCount = 0, oFull = 0, oDone = 0, oChecksum = 0; memory contents retained.
REQ-021 iClear has priority over a simultaneous iValid: the write is dropped, nothing stored.
REQ-022 Read: oRdData <= mem[iRdAddr] every rising edge; latency 1 cycle, always enabled, independent of state.
REQ-023 Read and write to the same address in the same cycle: oRdData returns the old (pre-write) content.
REQ-024 oFull is registered and equals (oCount == DEPTH).

Reset
REQ-025 iReset asserted forces immediately, regardless of clock: FSM = FILL, wr_ptr = 0, oCount = 0, oFull = 0, oDone = 0, oRdData = 0, oChecksum = 0.
REQ-026 Memory array is not reset; contents undefined until written.
REQ-027 Reset asserted mid-fill aborts the sequence; first accepted write after release goes to address 0.

Configuration
REQ-028 Macro SEQ_RAM_WRITER_CHECKSUM_EN: when defined, oChecksum <= oChecksum + iData on each accepted write, wrapping modulo 2^WIDTH.
REQ-029 Without SEQ_RAM_WRITER_CHECKSUM_EN, no accumulator is instantiated and oChecksum is constant 0.

Verification
REQ-030 Reset, then iValid=1 with iData = 0x00..0x1F over 32 cycles -> oCount 0..32, oFull=1 and oDone=1 one cycle after the 32nd write, oReady=0 thereafter.
REQ-031 After full fill, sweep iRdAddr 0..31 -> oRdData equals 0x00..0x1F, each one cycle after its address.
REQ-032 In FULL, drive iValid=1, iData=0xAA for 5 cycles -> memory, oCount=32, oChecksum unchanged, oDone=0.
REQ-033 Write 10 bytes, assert iClear together with iValid (iData=0x55) -> oCount=0, mem[10] not written; next write of 0x77 lands at address 0.
REQ-034 With SEQ_RAM_WRITER_CHECKSUM_EN, write 0xFF, 0x02, 0x10 -> oChecksum = 0x11; without macro -> oChecksum = 0x00.
REQ-035 Assert iReset asynchronously (between clock edges) after 7 writes -> all outputs zero immediately; after release, write 0x3C -> read address 0 returns 0x3C, oCount=1.

Source files
------------

// File: rtl/seq_ram_writer.sv
// Sequential-fill RAM writer: stores accepted bytes at addresses 0..DEPTH-1 in order, with registered readback.
// Optional running checksum of accepted bytes when SEQ_RAM_WRITER_CHECKSUM_EN is defined.
module seq_ram_writer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iValid,
    input  logic [WIDTH-1:0] iData,
    output logic             oReady,
    input  logic             iClear,
    input  logic [AW-1:0]    iRdAddr,
    output logic [WIDTH-1:0] oRdData,
    output logic [AW:0]      oCount,
    output logic             oFull,
    output logic             oDone,
    output logic [WIDTH-1:0] oChecksum
);

    typedef enum logic {FILL, FULL} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    state_t           nextState;
    logic [AW-1:0]    wrPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             accept;

    // A clear in the same cycle drops the write entirely.
    always_comb begin
        accept = iValid && oReady && !iClear;
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state <= FILL;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (iClear) begin
            nextState = FILL;
        end else if (state == FILL && accept && wrPtr == LAST_ADDR) begin
            nextState = FULL;
        end
    end

    always_comb begin
        oReady = (state == FILL);
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            wrPtr  <= '0;
            oCount <= '0;
            oFull  <= 1'b0;
            oDone  <= 1'b0;
        end else if (iClear) begin
            wrPtr  <= '0;
            oCount <= '0;
            oFull  <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (accept) begin
                wrPtr  <= wrPtr + 1'b1;
                oCount <= oCount + 1'b1;
                if (wrPtr == LAST_ADDR) begin
                    oFull <= 1'b1;
                    oDone <= 1'b1;
                end
            end
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge iClk) begin
        if (accept) begin
            mem[wrPtr] <= iData;
        end
    end

    // Read-before-write: same-address collision returns the old content.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oRdData <= '0;
        end else begin
            oRdData <= mem[iRdAddr];
        end
    end

`ifdef SEQ_RAM_WRITER_CHECKSUM_EN
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oChecksum <= '0;
        end else if (iClear) begin
            oChecksum <= '0;
        end else if (accept) begin
            oChecksum <= oChecksum + iData;
        end
    end
`else
    assign oChecksum = '0;
`endif

endmodule
